// File: rtl/systempll_lock_sequencer.sv
// systempll_lock_sequencer
//
// Sequences bring-up of the F-tile system PLL from the management clock domain.
// The block holds the refclk monitor off for a settle period, then waits for a
// stable synth-lock, and then releases the downstream datapath reset. While
// running, it watches synth-lock and a refclk-domain heartbeat. On a failure it
// re-arms automatically and counts the event.
//
// Ports
//   clk                     management clock (free running)
//   reset_n                 synchronous active-low reset
//   in_synthlock            PLL synth-lock (asynchronous)
//   in_refclk_hb            divided-refclk toggle (asynchronous)
//   force_relock            level-sampled request to restart the sequence
//   disable_refclk_monitor  1 while in SETTLE (holds the PLL refclk monitor off)
//   rst_out_n               downstream reset, released only in RUN
//   locked                  qualified lock status (same as rst_out_n)
//   state                   0=SETTLE, 1=WAIT_LOCK, 2=RUN
//   lock_loss_count         saturating count of failure exits from RUN
//   timeout_count           saturating count of WAIT_LOCK timeouts
module systempll_lock_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned LOCK_STABLE   = 256,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned HB_TIMEOUT    = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_synthlock,
  input  logic             in_refclk_hb,
  input  logic             force_relock,
  output logic             disable_refclk_monitor,
  output logic             rst_out_n,
  output logic             locked,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  typedef enum logic [1:0] {
    SETTLE    = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        lock_meta, lock_s;
  logic [2:0]  hb_q;
  logic        hb_edge;
  // cyc_q serves as the settle counter, the lock timeout counter and the
  // heartbeat counter. Only one of them is live in any given state, and the
  // counter is cleared on every state change.
  logic [31:0] cyc_q, cyc_d, cyc_inc;
  logic [31:0] stable_q, stable_d, stable_inc;
  logic        loss_inc, timeout_inc;

  assign hb_edge = hb_q[2] ^ hb_q[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      hb_q      <= '0;
    end else begin
      lock_meta <= in_synthlock;
      lock_s    <= lock_meta;
      hb_q      <= {hb_q[1:0], in_refclk_hb};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= SETTLE;
      cyc_q    <= '0;
      stable_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_inc     = cyc_q + 32'd1;
    stable_inc  = stable_q + 32'd1;
    cyc_d       = cyc_inc;
    stable_d    = '0;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;
    if (force_relock) begin
      state_d = SETTLE;
      cyc_d   = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cyc_inc >= SETTLE_CYCLES) begin
            state_d = WAIT_LOCK;
            cyc_d   = '0;
          end
        end
        WAIT_LOCK: begin
          stable_d = lock_s ? stable_inc : '0;
          // Reaching the stable count wins over a coincident timeout.
          if (lock_s && (stable_inc >= LOCK_STABLE)) begin
            state_d  = RUN;
            cyc_d    = '0;
            stable_d = '0;
          end else if (cyc_inc >= LOCK_TIMEOUT) begin
            state_d     = SETTLE;
            cyc_d       = '0;
            stable_d    = '0;
            timeout_inc = 1'b1;
          end
        end
        RUN: begin
          if (hb_edge) begin
            cyc_d = '0;
          end
          // A lock drop and a heartbeat stall in the same cycle are one failure.
          if (!lock_s ||
              ((HB_TIMEOUT != 0) && !hb_edge && (cyc_inc >= HB_TIMEOUT))) begin
            state_d  = SETTLE;
            cyc_d    = '0;
            loss_inc = 1'b1;
          end
        end
        default: begin
          state_d = SETTLE;
          cyc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
      timeout_count   <= '0;
    end else begin
      if (loss_inc && (lock_loss_count != '1)) begin
        lock_loss_count <= lock_loss_count + CNT_W'(1);
      end
      if (timeout_inc && (timeout_count != '1)) begin
        timeout_count <= timeout_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    disable_refclk_monitor = (state_q == SETTLE);
    rst_out_n              = (state_q == RUN);
    locked                 = (state_q == RUN);
    state                  = state_q;
  end

endmodule

// File: tb/tb_systempll_lock_sequencer.sv
// tb_systempll_lock_sequencer
//
// Directed bench for systempll_lock_sequencer. It uses two instances that share
// the same inputs. The main instance has HB_TIMEOUT=20, and the second instance
// has HB_TIMEOUT=0 (no heartbeat check). Expected values are cycle counts that
// were worked out by hand from the sequencing rules.
module tb_systempll_lock_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       in_synthlock;
  logic       in_refclk_hb;
  logic       force_relock;
  logic       dis, rst_n_o, lck;
  logic [1:0] st;
  logic [1:0] loss_cnt, to_cnt;
  logic       n_dis, n_rst_n_o, n_lck;
  logic [1:0] n_st;
  logic [1:0] n_loss_cnt, n_to_cnt;

  int checks   = 0;
  int failures = 0;

  logic hb_en    = 1'b1;
  int   kick_req = 0;
  int   kick_done;
  int   hb_div;

  systempll_lock_sequencer #(
    .SETTLE_CYCLES(16), .LOCK_STABLE(8), .LOCK_TIMEOUT(100),
    .HB_TIMEOUT(20), .CNT_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_synthlock(in_synthlock),
    .in_refclk_hb(in_refclk_hb), .force_relock(force_relock),
    .disable_refclk_monitor(dis), .rst_out_n(rst_n_o), .locked(lck),
    .state(st), .lock_loss_count(loss_cnt), .timeout_count(to_cnt)
  );

  systempll_lock_sequencer #(
    .SETTLE_CYCLES(16), .LOCK_STABLE(8), .LOCK_TIMEOUT(100),
    .HB_TIMEOUT(0), .CNT_W(2)
  ) dut_nohb (
    .clk(clk), .reset_n(reset_n), .in_synthlock(in_synthlock),
    .in_refclk_hb(in_refclk_hb), .force_relock(force_relock),
    .disable_refclk_monitor(n_dis), .rst_out_n(n_rst_n_o), .locked(n_lck),
    .state(n_st), .lock_loss_count(n_loss_cnt), .timeout_count(n_to_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Heartbeat generator. It toggles every 4 cycles while hb_en is set. A kick
  // request gives a single toggle at a known cycle.
  initial begin
    in_refclk_hb = 1'b0;
    hb_div       = 0;
    kick_done    = 0;
    forever begin
      @(posedge clk);
      #2;
      if (kick_req != kick_done) begin
        kick_done    = kick_req;
        in_refclk_hb = ~in_refclk_hb;
        hb_div       = 0;
      end else if (hb_en) begin
        hb_div++;
        if (hb_div >= 4) begin
          hb_div       = 0;
          in_refclk_hb = ~in_refclk_hb;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    in_synthlock = 1'b1;
    force_relock = 1'b0;
    step(3);
    reset_n = 1'b1;

    // Reset state and clean bring-up. This point is cycle 0.
    check("rst_state", st, 0);
    check("rst_dis", dis, 1);
    check("rst_rstn", rst_n_o, 0);
    check("rst_locked", lck, 0);
    check("rst_loss", loss_cnt, 0);
    check("rst_to", to_cnt, 0);
    check("rst_nohb_dis", n_dis, 1);
    for (int k = 1; k < 16; k++) begin
      step(1);
      check("bringup_dis", dis, 1);
    end
    step(1);
    check("bringup_wait_state", st, 1);
    check("bringup_wait_dis", dis, 0);
    step(7);
    check("bringup_c23_rstn", rst_n_o, 0);
    step(1);
    check("bringup_c24_rstn", rst_n_o, 1);
    check("bringup_c24_locked", lck, 1);
    check("bringup_c24_state", st, 2);
    check("bringup_nohb_rstn", n_rst_n_o, 1);
    check("bringup_nohb_locked", n_lck, 1);
    check("bringup_loss", loss_cnt, 0);
    check("bringup_to", to_cnt, 0);
    step(40);
    check("hb_run_state", st, 2);

    // Heartbeat stall. The final edge is cleared at E3, and the exit happens at E23.
    hb_en = 1'b0;
    kick_req++;
    step(22);
    check("stall_c22_state", st, 2);
    step(1);
    check("stall_exit_state", st, 0);
    check("stall_exit_rstn", rst_n_o, 0);
    check("stall_loss", loss_cnt, 1);
    check("stall_nohb_state", n_st, 2);
    hb_en = 1'b1;
    step(23);
    check("stall_rebring_c23", st, 1);
    step(1);
    check("stall_rebring_c24", st, 2);
    check("stall_nohb_still_run", n_st, 2);
    check("stall_nohb_loss", n_loss_cnt, 0);
    step(10);

    // Lock drop and heartbeat timeout in the same cycle (E23).
    hb_en = 1'b0;
    kick_req++;
    step(20);
    in_synthlock = 1'b0;
    step(2);
    check("both_c22_state", st, 2);
    step(1);
    check("both_exit_state", st, 0);
    check("both_loss", loss_cnt, 2);
    check("both_nohb_loss", n_loss_cnt, 1);
    in_synthlock = 1'b1;
    hb_en = 1'b1;
    step(24);
    check("both_rebring", st, 2);
    check("both_nohb_rebring", n_st, 2);
    step(10);

    // Force relock pulse in RUN.
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    check("force_state", st, 0);
    check("force_nohb_state", n_st, 0);
    check("force_loss", loss_cnt, 2);
    check("force_nohb_loss", n_loss_cnt, 1);
    step(24);
    check("force_rebring", st, 2);

    // Force relock in the same cycle that the FSM sees a lock drop.
    in_synthlock = 1'b0;
    step(2);
    force_relock = 1'b1;
    check("force_drop_pre", st, 2);
    step(1);
    force_relock = 1'b0;
    in_synthlock = 1'b1;
    check("force_drop_state", st, 0);
    check("force_drop_loss", loss_cnt, 2);
    check("force_drop_nohb_loss", n_loss_cnt, 1);
    step(24);
    check("force_drop_rebring", st, 2);

    // Lock drop in RUN: the reset falls on the third edge.
    in_synthlock = 1'b0;
    step(2);
    check("drop_e2_state", st, 2);
    check("drop_e2_rstn", rst_n_o, 1);
    step(1);
    check("drop_e3_state", st, 0);
    check("drop_e3_rstn", rst_n_o, 0);
    check("drop_e3_dis", dis, 1);
    check("drop_loss", loss_cnt, 3);
    check("drop_nohb_loss", n_loss_cnt, 2);
    in_synthlock = 1'b1;
    for (int k = 1; k < 16; k++) begin
      step(1);
      check("drop_settle_dis", dis, 1);
    end
    step(1);
    check("drop_wait_state", st, 1);
    check("drop_wait_dis", dis, 0);
    step(8);
    check("drop_rebring", st, 2);

    // Holding force_relock high keeps the block in SETTLE with the counter at 0.
    force_relock = 1'b1;
    step(30);
    check("hold_state", st, 0);
    check("hold_dis", dis, 1);
    force_relock = 1'b0;
    step(15);
    check("hold_rel_c15", st, 0);
    step(1);
    check("hold_rel_c16", st, 1);
    step(8);
    check("hold_rel_run", st, 2);

    // Lock never asserts: the block times out every 116 cycles, and the count saturates at 3.
    in_synthlock = 1'b0;
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    step(15);
    check("nolock_c15", st, 0);
    step(1);
    check("nolock_c16", st, 1);
    step(99);
    check("nolock_c115", st, 1);
    check("nolock_to0", to_cnt, 0);
    step(1);
    check("nolock_t1_state", st, 0);
    check("nolock_t1_cnt", to_cnt, 1);
    for (int n = 2; n <= 5; n++) begin
      step(115);
      check("nolock_wait", st, 1);
      step(1);
      check("nolock_state", st, 0);
      check("nolock_cnt", to_cnt, (n > 3) ? 3 : n);
      check("nolock_nohb_cnt", n_to_cnt, (n > 3) ? 3 : n);
    end

    // One-cycle glitch at WAIT_LOCK cycle 5 restarts the stable count.
    in_synthlock = 1'b1;
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    step(21);
    in_synthlock = 1'b0;
    step(1);
    in_synthlock = 1'b1;
    step(9);
    check("glitch_c31_state", st, 1);
    step(1);
    check("glitch_c32_state", st, 2);

    // Reset in the middle of RUN.
    step(5);
    check("midrst_pre", st, 2);
    reset_n = 1'b0;
    step(1);
    check("midrst_state", st, 0);
    check("midrst_dis", dis, 1);
    check("midrst_rstn", rst_n_o, 0);
    check("midrst_locked", lck, 0);
    check("midrst_loss", loss_cnt, 0);
    check("midrst_to", to_cnt, 0);
    check("midrst_nohb_rstn", n_rst_n_o, 0);
    reset_n = 1'b1;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
